// File: rtl/cpu_pkg.sv
// Shared types for the fetch next-PC controller:
// branch-type codes, stage-register bundle, FSM states.
package cpu_pkg;

   localparam logic [1:0] BT_OTHER  = 2'b00;
   localparam logic [1:0] BT_JAL    = 2'b01;
   localparam logic [1:0] BT_BRANCH = 2'b10;
   localparam logic [1:0] BT_JALR   = 2'b11;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic        pTaken;
      logic [31:0] pTarget;
   } stage_t;

   typedef enum logic {RUN, PEND} fsm_e;

   typedef enum logic {RD_MRET, RD_TRAP} rd_kind_e;

   function automatic logic [31:0] pc_align(
      input logic [31:0] pc
   );
      return {pc[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_pc_ctrl_if.sv
// Bus between the fetch next-PC controller and its
// surroundings. master drives requests, slave is the controller.
interface fetch_pc_ctrl_if #(
   parameter int CNT_WIDTH = 32
);
   logic                 IF_DONE;
   logic                 MEM_DONE;
   logic                 ID_stall;
   logic                 IF_pTaken;
   logic [31:0]          IF_pTarget;
   logic [1:0]           EX_bType;
   logic                 EX_rTaken;
   logic [31:0]          EX_bTarget;
   logic                 trap_valid;
   logic [31:0]          trap_vector;
   logic                 mret_valid;
   logic [31:0]          mepc;
   logic [31:0]          IF_PC;
   logic [31:0]          ID_PC;
   logic [31:0]          EX_PC;
   logic                 EX_valid;
   logic                 flush_IFID;
   logic                 flush_IDEX;
   logic [CNT_WIDTH-1:0] br_cnt;
   logic [CNT_WIDTH-1:0] miss_cnt;

   modport master (
      output IF_DONE, MEM_DONE, ID_stall,
      output IF_pTaken, IF_pTarget,
      output EX_bType, EX_rTaken, EX_bTarget,
      output trap_valid, trap_vector,
      output mret_valid, mepc,
      input  IF_PC, ID_PC, EX_PC, EX_valid,
      input  flush_IFID, flush_IDEX,
      input  br_cnt, miss_cnt
   );

   modport slave (
      input  IF_DONE, MEM_DONE, ID_stall,
      input  IF_pTaken, IF_pTarget,
      input  EX_bType, EX_rTaken, EX_bTarget,
      input  trap_valid, trap_vector,
      input  mret_valid, mepc,
      output IF_PC, ID_PC, EX_PC, EX_valid,
      output flush_IFID, flush_IDEX,
      output br_cnt, miss_cnt
   );

endinterface

// File: rtl/fetch_pc_ctrl_mispredict_check.sv
// EX-stage prediction check. In: EX stage bundle, resolved
// type/outcome/target. Out: miss_o, correct_pc_o.
module mispredict_check
   import cpu_pkg::*;
(
   input  stage_t      ex_i,
   input  logic [1:0]  bType_i,
   input  logic        rTaken_i,
   input  logic [31:0] bTarget_i,
   output logic        miss_o,
   output logic [31:0] correct_pc_o
);

   logic [31:0] seq_pc;
   logic        raw_miss;
   logic        tgt_diff;

   assign seq_pc   = ex_i.pc + 32'd4;
   assign tgt_diff = ex_i.pTarget != bTarget_i;

   always_comb begin
      raw_miss     = 1'b0;
      correct_pc_o = seq_pc;
      unique case (bType_i)
         BT_BRANCH: begin
            raw_miss = (ex_i.pTaken != rTaken_i)
                     | (ex_i.pTaken & rTaken_i & tgt_diff);
            correct_pc_o = rTaken_i ? bTarget_i : seq_pc;
         end
         BT_JAL, BT_JALR: begin
            raw_miss     = ~ex_i.pTaken | tgt_diff;
            correct_pc_o = bTarget_i;
         end
         default: begin
            // Predicted taken on a non-branch: stale BTB alias.
            raw_miss     = ex_i.pTaken;
            correct_pc_o = seq_pc;
         end
      endcase
   end

   assign miss_o = ex_i.valid & raw_miss;

endmodule

// File: rtl/fetch_pc_ctrl.sv
// Fetch next-PC controller: owns IF PC, ID/EX stage regs,
// redirects (trap/mret/mispredict), flushes and perf counters.
// Ports: clk, rst (async high), bus (fetch_pc_ctrl_if.slave).
module fetch_pc_ctrl
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          CNT_WIDTH = 32
) (
   input  logic              clk,
   input  logic              rst,
   fetch_pc_ctrl_if.slave    bus
);

   logic [31:0]          pc_q;
   stage_t               id_q;
   stage_t               ex_q;
   fsm_e                 state_q;
   rd_kind_e             kind_q;
   logic [31:0]          addr_q;
   logic [CNT_WIDTH-1:0] br_q;
   logic [CNT_WIDTH-1:0] miss_q;

   logic        adv;
   logic        miss;
   logic [31:0] correct_pc;
   logic        pend_trap;
   logic        pend_mret;
   logic        eff_trap;
   logic        eff_mret;
   logic        redirect;
   logic [31:0] redir_pc;
   logic [31:0] seq_pc;

   mispredict_check u_chk (
      .ex_i         (ex_q),
      .bType_i      (bus.EX_bType),
      .rTaken_i     (bus.EX_rTaken),
      .bTarget_i    (bus.EX_bTarget),
      .miss_o       (miss),
      .correct_pc_o (correct_pc)
   );

   assign adv = bus.IF_DONE & bus.MEM_DONE;

   assign pend_trap = (state_q == PEND)
                    & (kind_q == RD_TRAP);
   assign pend_mret = (state_q == PEND)
                    & (kind_q == RD_MRET);

   // A latched request outranks a mispredict seen
   // in the cycle it is finally applied.
   assign eff_trap = bus.trap_valid | pend_trap;
   assign eff_mret = bus.mret_valid | pend_mret;
   assign redirect = adv & (eff_trap | eff_mret | miss);

   always_comb begin
      redir_pc = correct_pc;
      if (eff_trap) begin
         redir_pc = bus.trap_valid ? bus.trap_vector
                                   : addr_q;
      end else if (eff_mret) begin
         redir_pc = pend_mret ? addr_q : bus.mepc;
      end
   end

   assign seq_pc = bus.IF_pTaken ? bus.IF_pTarget
                                 : pc_q + 32'd4;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q    <= RESET_PC;
         id_q    <= '0;
         ex_q    <= '0;
         state_q <= RUN;
         kind_q  <= RD_MRET;
         addr_q  <= '0;
         br_q    <= '0;
         miss_q  <= '0;
      end else begin
         if (adv) begin
            if (redirect) begin
               pc_q        <= pc_align(redir_pc);
               id_q.valid  <= 1'b0;
               id_q.pTaken <= 1'b0;
               ex_q.valid  <= 1'b0;
               ex_q.pTaken <= 1'b0;
            end else if (bus.ID_stall) begin
               // IF and ID hold; a bubble enters EX.
               ex_q.valid  <= 1'b0;
               ex_q.pTaken <= 1'b0;
            end else begin
               pc_q <= pc_align(seq_pc);
               id_q <= '{valid:   1'b1,
                         pc:      pc_q,
                         pTaken:  bus.IF_pTaken,
                         pTarget: bus.IF_pTarget};
               ex_q <= id_q;
            end
            if (ex_q.valid && bus.EX_bType != BT_OTHER) begin
               br_q <= br_q + CNT_WIDTH'(1);
               if (miss) begin
                  miss_q <= miss_q + CNT_WIDTH'(1);
               end
            end
         end

         unique case (state_q)
            RUN: begin
               if (!adv &&
                   (bus.trap_valid || bus.mret_valid)) begin
                  state_q <= PEND;
                  if (bus.trap_valid) begin
                     kind_q <= RD_TRAP;
                     addr_q <= bus.trap_vector;
                  end else begin
                     kind_q <= RD_MRET;
                     addr_q <= bus.mepc;
                  end
               end
            end
            PEND: begin
               if (adv) begin
                  state_q <= RUN;
               end else if (bus.trap_valid) begin
                  // A trap replaces anything latched;
                  // a later mret never displaces a trap.
                  kind_q <= RD_TRAP;
                  addr_q <= bus.trap_vector;
               end
            end
            default: state_q <= RUN;
         endcase
      end
   end

   assign bus.IF_PC      = pc_q;
   assign bus.ID_PC      = id_q.pc;
   assign bus.EX_PC      = ex_q.pc;
   assign bus.EX_valid   = ex_q.valid;
   assign bus.flush_IFID = redirect;
   assign bus.flush_IDEX = redirect;
   assign bus.br_cnt     = br_q;
   assign bus.miss_cnt   = miss_q;

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Scoreboard bench for fetch_pc_ctrl: driver queues expected
// values per cycle, a negedge monitor pops and compares.
module tb_fetch_pc_ctrl;

   localparam int F_IF   = 0;
   localparam int F_ID   = 1;
   localparam int F_EX   = 2;
   localparam int F_EXV  = 3;
   localparam int F_FL1  = 4;
   localparam int F_FL2  = 5;
   localparam int F_BR   = 6;
   localparam int F_MISS = 7;

   typedef struct {
      int          cyc;
      int          sel;
      logic [31:0] val;
      string       name;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_tot = 0;
   int   n_pass = 0;
   exp_t sb[$];

   fetch_pc_ctrl_if #(.CNT_WIDTH(32)) bus ();

   fetch_pc_ctrl #(
      .RESET_PC  (32'h100),
      .CNT_WIDTH (32)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] actual(int sel);
      case (sel)
         F_IF:   return bus.IF_PC;
         F_ID:   return bus.ID_PC;
         F_EX:   return bus.EX_PC;
         F_EXV:  return {31'd0, bus.EX_valid};
         F_FL1:  return {31'd0, bus.flush_IFID};
         F_FL2:  return {31'd0, bus.flush_IDEX};
         F_BR:   return bus.br_cnt;
         default: return bus.miss_cnt;
      endcase
   endfunction

   task automatic c(int sel, logic [31:0] v, string n);
      exp_t e;
      e.cyc  = cyc;
      e.sel  = sel;
      e.val  = v;
      e.name = n;
      sb.push_back(e);
   endtask

   task automatic fl(logic v, string n);
      c(F_FL1, {31'd0, v}, {n, "_fIFID"});
      c(F_FL2, {31'd0, v}, {n, "_fIDEX"});
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         exp_t e;
         logic [31:0] a;
         e = sb.pop_front();
         a = actual(e.sel);
         n_tot++;
         if (e.cyc != cyc) begin
            $display("FAIL %s: not sampled in cycle %0d",
                     e.name, e.cyc);
         end else if (a !== e.val) begin
            $display("FAIL %s: got %h expected %h",
                     e.name, a, e.val);
         end else begin
            n_pass++;
         end
      end
   end

   initial begin
      bus.IF_DONE     = 1'b1;
      bus.MEM_DONE    = 1'b1;
      bus.ID_stall    = 1'b0;
      bus.IF_pTaken   = 1'b0;
      bus.IF_pTarget  = 32'h0;
      bus.EX_bType    = 2'b00;
      bus.EX_rTaken   = 1'b0;
      bus.EX_bTarget  = 32'h0;
      bus.trap_valid  = 1'b0;
      bus.trap_vector = 32'h0;
      bus.mret_valid  = 1'b0;
      bus.mepc        = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      // reset state
      c(F_IF, 32'h100, "rst_if");
      c(F_ID, 32'h0, "rst_id");
      c(F_EX, 32'h0, "rst_ex");
      c(F_EXV, 32'h0, "rst_exv");
      fl(1'b0, "rst");
      c(F_BR, 32'h0, "rst_br");
      c(F_MISS, 32'h0, "rst_miss");
      tick();
      rst = 1'b0;
      // S0..S2 sequential fetch
      c(F_IF, 32'h100, "s0_if");
      fl(1'b0, "s0");
      tick();
      c(F_IF, 32'h104, "s1_if");
      c(F_ID, 32'h100, "s1_id");
      c(F_EXV, 32'h0, "s1_exv");
      tick();
      c(F_IF, 32'h108, "s2_if");
      c(F_EX, 32'h100, "s2_ex");
      c(F_EXV, 32'h1, "s2_exv");
      fl(1'b0, "s2");
      bus.IF_pTaken  = 1'b1;
      bus.IF_pTarget = 32'h200;
      tick();
      // S3 predicted-taken redirect
      bus.IF_pTaken = 1'b0;
      c(F_IF, 32'h200, "pred_if");
      c(F_ID, 32'h108, "pred_id");
      tick();
      // S4 correct B-type prediction
      bus.EX_bType   = 2'b10;
      bus.EX_rTaken  = 1'b1;
      bus.EX_bTarget = 32'h200;
      c(F_EX, 32'h108, "okbr_ex");
      fl(1'b0, "okbr");
      tick();
      // S5 br_cnt=1, mret redirect to 120
      bus.EX_bType = 2'b00;
      bus.EX_rTaken = 1'b0;
      c(F_BR, 32'h1, "okbr_br");
      c(F_MISS, 32'h0, "okbr_miss");
      bus.mret_valid = 1'b1;
      bus.mepc       = 32'h120;
      fl(1'b1, "mret");
      tick();
      // S6
      bus.mret_valid = 1'b0;
      c(F_IF, 32'h120, "mret_if");
      c(F_EXV, 32'h0, "mret_exv");
      fl(1'b0, "s6");
      bus.IF_pTaken  = 1'b1;
      bus.IF_pTarget = 32'h400;
      tick();
      // S7
      bus.IF_pTaken = 1'b0;
      c(F_IF, 32'h400, "s7_if");
      c(F_ID, 32'h120, "s7_id");
      tick();
      // S8 B-type predicted taken, resolves not taken
      bus.EX_bType   = 2'b10;
      bus.EX_rTaken  = 1'b0;
      bus.EX_bTarget = 32'h400;
      c(F_EX, 32'h120, "bmiss_ex");
      fl(1'b1, "bmiss");
      tick();
      // S9, S10 two bubbles
      bus.EX_bType = 2'b00;
      c(F_IF, 32'h124, "bmiss_if");
      c(F_EXV, 32'h0, "bub1_exv");
      c(F_MISS, 32'h1, "bmiss_miss");
      c(F_BR, 32'h2, "bmiss_br");
      fl(1'b0, "s9");
      tick();
      c(F_IF, 32'h128, "s10_if");
      c(F_ID, 32'h124, "s10_id");
      c(F_EXV, 32'h0, "bub2_exv");
      tick();
      // S11 JALR not predicted
      c(F_EX, 32'h124, "jalr_ex");
      bus.EX_bType   = 2'b11;
      bus.EX_bTarget = 32'h3000;
      fl(1'b1, "jalr");
      tick();
      // S12
      bus.EX_bType = 2'b00;
      c(F_IF, 32'h3000, "jalr_if");
      c(F_MISS, 32'h2, "jalr_miss");
      c(F_BR, 32'h3, "jalr_br");
      fl(1'b0, "s12");
      tick();
      tick();
      // S14 trap while MEM_DONE low, EX mispredict
      c(F_EX, 32'h3000, "s14_ex");
      bus.MEM_DONE    = 1'b0;
      bus.trap_valid  = 1'b1;
      bus.trap_vector = 32'h80;
      bus.EX_bType    = 2'b11;
      bus.EX_bTarget  = 32'h5000;
      fl(1'b0, "stall14");
      tick();
      // S15 later mret must not displace trap
      bus.trap_valid  = 1'b0;
      bus.trap_vector = 32'hDEAD0;
      bus.mret_valid  = 1'b1;
      bus.mepc        = 32'h700;
      c(F_IF, 32'h3008, "hold_if");
      c(F_EXV, 32'h1, "hold_exv");
      fl(1'b0, "stall15");
      tick();
      // S16
      bus.mret_valid = 1'b0;
      fl(1'b0, "stall16");
      tick();
      // S17 first adv applies latched trap
      bus.MEM_DONE = 1'b1;
      fl(1'b1, "trap");
      tick();
      // S18
      bus.EX_bType = 2'b00;
      c(F_IF, 32'h80, "trap_if");
      c(F_EXV, 32'h0, "trap_exv");
      c(F_BR, 32'h4, "trap_br");
      c(F_MISS, 32'h3, "trap_miss");
      fl(1'b0, "s18");
      tick();
      tick();
      // S20 start ID_stall for 2 adv cycles
      c(F_IF, 32'h88, "s20_if");
      c(F_ID, 32'h84, "s20_id");
      c(F_EX, 32'h80, "s20_ex");
      bus.ID_stall = 1'b1;
      tick();
      c(F_IF, 32'h88, "stl1_if");
      c(F_ID, 32'h84, "stl1_id");
      c(F_EXV, 32'h0, "stl1_exv");
      tick();
      bus.ID_stall = 1'b0;
      c(F_IF, 32'h88, "stl2_if");
      c(F_ID, 32'h84, "stl2_id");
      c(F_EXV, 32'h0, "stl2_exv");
      c(F_BR, 32'h4, "stl_br");
      c(F_MISS, 32'h3, "stl_miss");
      tick();
      // S23 mret to unaligned top address
      c(F_IF, 32'h8C, "s23_if");
      c(F_EX, 32'h84, "s23_ex");
      c(F_EXV, 32'h1, "s23_exv");
      bus.mret_valid = 1'b1;
      bus.mepc       = 32'hFFFF_FFFE;
      fl(1'b1, "wrapm");
      tick();
      bus.mret_valid = 1'b0;
      c(F_IF, 32'hFFFF_FFFC, "align_if");
      tick();
      // S25 wrap, then latch a trap
      c(F_IF, 32'h0, "wrap_if");
      bus.MEM_DONE    = 1'b0;
      bus.trap_valid  = 1'b1;
      bus.trap_vector = 32'h900;
      tick();
      // S26 async reset discards pending trap
      bus.trap_valid = 1'b0;
      rst = 1'b1;
      c(F_IF, 32'h100, "arst_if");
      c(F_EXV, 32'h0, "arst_exv");
      tick();
      rst = 1'b0;
      bus.MEM_DONE = 1'b1;
      fl(1'b0, "nopend");
      tick();
      c(F_IF, 32'h104, "nopend_if");
      tick();
      repeat (2) @(negedge clk);
      while (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         n_tot++;
         $display("FAIL %s: never compared", e.name);
      end
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1);
   end

endmodule

// File: doc/fetch_pc_ctrl.md
# fetch_pc_ctrl

Fetch-side next-PC controller. It sits directly upstream of the branch predictor: it owns the fetch PC register, selects the next PC from prediction, misprediction recovery and trap/return redirects, and pipelines each instruction's PC and prediction into ID and EX. At EX it checks the prediction against the resolved outcome, then drives the predictor's IF/EX PC inputs and the pipeline flushes.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset
- CNT_WIDTH, 32, width of the performance counters

- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- IF_DONE  in  1  instruction fetch complete
- MEM_DONE  in  1  data access complete
- ID_stall  in  1  load-use hazard: hold IF/ID, bubble into EX
- IF_pTaken  in  1  predictor taken for IF_PC
- IF_pTarget  in  32  predictor target for IF_PC
- EX_bType  in  2  00 other, 01 JAL, 10 B-type, 11 JALR
- EX_rTaken  in  1  resolved B-type outcome
- EX_bTarget  in  32  resolved target
- trap_valid  in  1  trap request pulse
- trap_vector  in  32  trap handler address
- mret_valid  in  1  MRET request pulse
- mepc  in  32  return address
- IF_PC  out  32  current fetch PC
- ID_PC  out  32  PC in ID
- EX_PC  out  32  PC in EX
- EX_valid  out  1  EX holds a real instruction
- flush_IFID  out  1  kill IF/ID contents
- flush_IDEX  out  1  kill ID/EX contents
- br_cnt  out  CNT_WIDTH  resolved control-transfer count
- miss_cnt  out  CNT_WIDTH  misprediction count

## Operation
- The pipeline advances only when `adv = IF_DONE && MEM_DONE`. Nothing advances otherwise.
- Stage registers: ID {valid, PC, pTaken, pTarget} and EX {valid, PC, pTaken, pTarget}.
- On `adv` with no ID_stall: IF moves into ID and ID moves into EX.
- On `adv` with ID_stall: IF_PC and ID hold, and EX.valid is set to 0 with pTaken cleared.
- EX mispredict check, evaluated only when EX.valid:
  - 10: mispredict if `pTaken != rTaken`, or if both are taken and `pTarget != bTarget`. Correct PC is `rTaken ? bTarget : EX_PC+4`.
  - 01/11: mispredict if `!pTaken` or `pTarget != bTarget`. Correct PC is bTarget.
  - 00: mispredict if pTaken (stale BTB alias). Correct PC is EX_PC+4.
- Next-PC priority on `adv`: trap_vector > mepc > mispredict-correct PC > IF_pTarget (if IF_pTaken) > IF_PC+4.
- Any redirect (trap, mret or mispredict) asserts flush_IFID and flush_IDEX and clears both valids and pTaken bits.
- A redirect overrides ID_stall.
- All PC arithmetic is 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 0.
- The low two bits of the next PC are forced to 0.
- Counters: on `adv` with EX.valid and bType != 00, br_cnt increments; miss_cnt also increments on a mispredict. Both wrap, with no saturation.
- FSM RUN / PEND:
  - RUN: if trap_valid or mret_valid arrives while `!adv`, latch {kind, address} and go to PEND.
  - PEND: on the next `adv`, apply the latched redirect and return to RUN. This outranks an EX mispredict in the same cycle.
  - PEND: a new trap_valid arriving in PEND overwrites a latched mret. A later mret never overwrites a latched trap.

## Timing
- Reset state: IF_PC = RESET_PC; ID/EX valid = 0; ID_PC = EX_PC = 0; flushes = 0; counters = 0; FSM = RUN.
- Reset mid-operation discards any pending redirect.
- IF_PC, ID_PC, EX_PC and EX_valid are registered.
- flush_IFID and flush_IDEX are combinational: high in the cycle the redirect is committed (`adv` together with a redirect source), low otherwise.
- Redirect latency is one edge. The corrected PC appears on IF_PC the cycle after the flush.
- A mispredict penalty is 2 bubbles.
- While `!adv`, an EX mispredict stays visible and is applied on the first `adv`. No latching is required, because EX holds.

## Structure
- Shared package cpu_pkg holds:
  - the bType constants BT_OTHER, BT_JAL, BT_BRANCH, BT_JALR;
  - the stage-register struct {valid, pc, pTaken, pTarget};
  - FSM state enum {RUN, PEND}.
- One combinational sub-module, mispredict_check: inputs EX stage struct and resolution; outputs {miss, correct_pc}.

## Test plan
- Reset with RESET_PC=32'h100, adv high -> IF_PC 100, 104, 108 on successive edges; no flushes.
- IF_pTaken=1, IF_pTarget=32'h200 at IF_PC=32'h108 -> next IF_PC=32'h200. When 108 reaches EX with bType=10, rTaken=1, bTarget=32'h200, there is no flush and br_cnt=1.
- B-type at EX_PC=32'h120, predicted taken, resolves not taken -> flush_IFID and flush_IDEX high one cycle; IF_PC=32'h124 next; miss_cnt=1.
- JALR at EX with pTaken=0, bTarget=32'h3000 -> flush, IF_PC=32'h3000, miss_cnt increments.
- trap_valid pulse (trap_vector=32'h80) while MEM_DONE=0 for 3 cycles, plus a concurrent EX mispredict -> FSM=PEND; on the first adv, IF_PC=32'h80 and both flushes fire once.
- ID_stall for 2 adv cycles -> IF_PC and ID_PC hold, EX_valid=0 both cycles, counters unchanged.
